decode_id: RTL and testbench

- Instruction-decode stage. It is the consumer of the IF/ID latch that the fetch stage drives.
- Reads `if_id_instr` and `if_id_npc`, decodes the opcode into control bundles, reads two operands from a 32x32 register file and sign-extends the immediate.
- Registers everything into the ID/EX latch.
- Accepts the writeback port from WB and a flush from EX/MEM branch resolution.

---
 rtl/decode_id_pkg.sv | 55 +++++
 rtl/decode_id_control_unit.sv | 20 ++
 rtl/decode_id_regfile.sv | 62 ++++++
 rtl/decode_id.sv | 139 +++++++++++++
 tb/tb_decode_id.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/decode_id_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, instruction
// field positions, control-bundle layout and small field-extraction helpers.
package decode_id_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int FIELD_W = 5;
    localparam int IMM_W   = 16;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;

    // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite},
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};

    function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rs(input logic [INSTR_W-1:0] instr);
        return instr[RS_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rt(input logic [INSTR_W-1:0] instr);
        return instr[RT_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_LSB +: FIELD_W];
    endfunction

    function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_LSB +: IMM_W];
    endfunction

endpackage

// File: rtl/decode_id_control_unit.sv
// Opcode to control-bundle decode; purely combinational.
module decode_id_control_unit
    import decode_id_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: ctrl = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
            OP_LW:    ctrl = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
            OP_SW:    ctrl = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
            OP_BEQ:   ctrl = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
            default:  ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/decode_id_regfile.sv
// Register file with hard-wired zero at index 0, asynchronous clear and
// write-through bypass so a same-cycle writeback is visible to decode.
module decode_id_regfile #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    localparam int NREG = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic              wr_en;

    assign wr_en = we && (waddr != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata1 = mem_q[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/decode_id.sv
// Instruction-decode stage: splits the IF/ID instruction, decodes controls,
// reads operands, sign-extends the immediate and registers all into ID/EX.
module decode_id
    import decode_id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    if_id_instr,
    input  logic [DATA_W-1:0]     if_id_npc,
    input  logic                  ex_mem_pc_src,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_write_data,
    output logic [WB_W-1:0]       id_ex_wb,
    output logic [M_W-1:0]        id_ex_m,
    output logic [EX_W-1:0]       id_ex_ex,
    output logic [DATA_W-1:0]     id_ex_npc,
    output logic [DATA_W-1:0]     id_ex_readdat1,
    output logic [DATA_W-1:0]     id_ex_readdat2,
    output logic [DATA_W-1:0]     id_ex_sign_ext,
    output logic [REG_ADDR_W-1:0] id_ex_instr_2016,
    output logic [REG_ADDR_W-1:0] id_ex_instr_1511,
    output logic                  id_ex_valid
);

    logic [OPC_W-1:0]      opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [IMM_W-1:0]      imm;
    ctrl_t                 ctrl;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;

    assign opcode = get_opcode(if_id_instr);
    assign rs     = get_rs(if_id_instr);
    assign rt     = get_rt(if_id_instr);
    assign rd     = get_rd(if_id_instr);
    assign imm    = get_imm(if_id_instr);

    decode_id_control_unit u_control_unit (
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    decode_id_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_reg_write),
        .waddr  (wb_write_reg),
        .wdata  (wb_write_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    logic [WB_W-1:0]       wb_d,    wb_q;
    logic [M_W-1:0]        m_d,     m_q;
    logic [EX_W-1:0]       ex_d,    ex_q;
    logic [DATA_W-1:0]     npc_d,   npc_q;
    logic [DATA_W-1:0]     rd1_d,   rd1_q;
    logic [DATA_W-1:0]     rd2_d,   rd2_q;
    logic [DATA_W-1:0]     sext_d,  sext_q;
    logic [REG_ADDR_W-1:0] rt_d,    rt_q;
    logic [REG_ADDR_W-1:0] rd_d,    rd_q;
    logic                  valid_d, valid_q;

    // A taken branch squashes the instruction in decode; the regfile write
    // port is independent of this and still commits.
    always_comb begin
        wb_d    = ctrl.wb;
        m_d     = ctrl.m;
        ex_d    = ctrl.ex;
        npc_d   = if_id_npc;
        rd1_d   = rdata1;
        rd2_d   = rdata2;
        sext_d  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        rt_d    = rt;
        rd_d    = rd;
        valid_d = 1'b1;
        if (ex_mem_pc_src) begin
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
            npc_d   = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            sext_d  = '0;
            rt_d    = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
            npc_q   <= npc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            sext_q  <= sext_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign id_ex_wb         = wb_q;
    assign id_ex_m          = m_q;
    assign id_ex_ex         = ex_q;
    assign id_ex_npc        = npc_q;
    assign id_ex_readdat1   = rd1_q;
    assign id_ex_readdat2   = rd2_q;
    assign id_ex_sign_ext   = sext_q;
    assign id_ex_instr_2016 = rt_q;
    assign id_ex_instr_1511 = rd_q;
    assign id_ex_valid      = valid_q;

endmodule

// File: tb/tb_decode_id.sv
// Directed self-checking bench for decode_id with hand-computed expectations.
module tb_decode_id;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        ex_mem_pc_src;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_readdat1;
    logic [31:0] id_ex_readdat2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_instr_2016;
    logic [4:0]  id_ex_instr_1511;
    logic        id_ex_valid;

    int n_checks = 0;
    int n_fail   = 0;

    decode_id dut (
        .clk              (clk),
        .rst              (rst),
        .if_id_instr      (if_id_instr),
        .if_id_npc        (if_id_npc),
        .ex_mem_pc_src    (ex_mem_pc_src),
        .wb_reg_write     (wb_reg_write),
        .wb_write_reg     (wb_write_reg),
        .wb_write_data    (wb_write_data),
        .id_ex_wb         (id_ex_wb),
        .id_ex_m          (id_ex_m),
        .id_ex_ex         (id_ex_ex),
        .id_ex_npc        (id_ex_npc),
        .id_ex_readdat1   (id_ex_readdat1),
        .id_ex_readdat2   (id_ex_readdat2),
        .id_ex_sign_ext   (id_ex_sign_ext),
        .id_ex_instr_2016 (id_ex_instr_2016),
        .id_ex_instr_1511 (id_ex_instr_1511),
        .id_ex_valid      (id_ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, where outputs are sampled
    // and the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic flush,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        if_id_instr   = instr;
        if_id_npc     = npc;
        ex_mem_pc_src = flush;
        wb_reg_write  = we;
        wb_write_reg  = wreg;
        wb_write_data = wdata;
    endtask

    initial begin
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("reset_valid", {31'b0, id_ex_valid}, 32'h0);
        check_eq("reset_wb", {30'b0, id_ex_wb}, 32'h0);
        tick();
        check_eq("reset_hold_valid", {31'b0, id_ex_valid}, 32'h0);
        rst = 1'b1;

        // All-zero instruction: R-type, reading r0, valid; preload r1 meanwhile
        drive(32'h0000_0000, 32'h0000_0004, 1'b0, 1'b1, 5'd1, 32'h0000_0100);
        tick();
        check_eq("zero_instr_valid", {31'b0, id_ex_valid}, 32'h1);
        check_eq("zero_instr_wb", {30'b0, id_ex_wb}, 32'h2);
        check_eq("zero_instr_ex", {28'b0, id_ex_ex}, 32'hC);
        check_eq("zero_instr_npc", id_ex_npc, 32'h0000_0004);

        drive(32'h0000_0000, 32'h0000_0008, 1'b0, 1'b1, 5'd2, 32'h0000_0005);
        tick();
        drive(32'h0000_0000, 32'h0000_000C, 1'b0, 1'b1, 5'd3, 32'h0000_0007);
        tick();

        // lw r2,4(r1)
        drive(32'h8C22_0004, 32'h0000_0010, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("lw_wb", {30'b0, id_ex_wb}, 32'h3);
        check_eq("lw_m", {29'b0, id_ex_m}, 32'h2);
        check_eq("lw_ex", {28'b0, id_ex_ex}, 32'h1);
        check_eq("lw_rd1", id_ex_readdat1, 32'h0000_0100);
        check_eq("lw_rd2", id_ex_readdat2, 32'h0000_0005);
        check_eq("lw_sext", id_ex_sign_ext, 32'h0000_0004);
        check_eq("lw_rt", {27'b0, id_ex_instr_2016}, 32'd2);
        check_eq("lw_valid", {31'b0, id_ex_valid}, 32'h1);
        check_eq("lw_npc", id_ex_npc, 32'h0000_0010);

        // add r4,r2,r3
        drive(32'h0043_2020, 32'h0000_0014, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("r_rd1", id_ex_readdat1, 32'h5);
        check_eq("r_rd2", id_ex_readdat2, 32'h7);
        check_eq("r_rd", {27'b0, id_ex_instr_1511}, 32'd4);
        check_eq("r_ex", {28'b0, id_ex_ex}, 32'hC);
        check_eq("r_m", {29'b0, id_ex_m}, 32'h0);
        check_eq("r_sext", id_ex_sign_ext, 32'h0000_2020);

        // Same-cycle write to r2 while it is read as rs
        drive(32'h0043_2020, 32'h0000_0018, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF);
        tick();
        check_eq("bypass_rd1", id_ex_readdat1, 32'hDEAD_BEEF);
        check_eq("bypass_rd2", id_ex_readdat2, 32'h7);
        drive(32'h0043_2020, 32'h0000_001C, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("bypass_commit", id_ex_readdat1, 32'hDEAD_BEEF);

        // Writes to r0 are discarded, including through the bypass path
        drive(32'h0000_0000, 32'h0000_0020, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check_eq("r0_bypass", id_ex_readdat1, 32'h0);
        drive(32'h0000_0000, 32'h0000_0024, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("r0_read", id_ex_readdat1, 32'h0);

        // beq r1,r2,-4 without flush
        drive(32'h1022_FFFC, 32'h0000_0028, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("beq_sext", id_ex_sign_ext, 32'hFFFF_FFFC);
        check_eq("beq_m", {29'b0, id_ex_m}, 32'h4);
        check_eq("beq_ex", {28'b0, id_ex_ex}, 32'h2);
        check_eq("beq_wb", {30'b0, id_ex_wb}, 32'h0);
        check_eq("beq_rd1", id_ex_readdat1, 32'h0000_0100);

        // Same beq flushed while r1 is written
        drive(32'h1022_FFFC, 32'h0000_002C, 1'b1, 1'b1, 5'd1, 32'h0000_0055);
        tick();
        check_eq("flush_valid", {31'b0, id_ex_valid}, 32'h0);
        check_eq("flush_m", {29'b0, id_ex_m}, 32'h0);
        check_eq("flush_sext", id_ex_sign_ext, 32'h0);
        check_eq("flush_rd1", id_ex_readdat1, 32'h0);
        check_eq("flush_npc", id_ex_npc, 32'h0);
        drive(32'h1022_FFFC, 32'h0000_0030, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("flush_write_commit", id_ex_readdat1, 32'h0000_0055);
        check_eq("post_flush_valid", {31'b0, id_ex_valid}, 32'h1);

        // sw r2,8(r1)
        drive(32'hAC22_0008, 32'h0000_0034, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("sw_m", {29'b0, id_ex_m}, 32'h1);
        check_eq("sw_ex", {28'b0, id_ex_ex}, 32'h1);
        check_eq("sw_wb", {30'b0, id_ex_wb}, 32'h0);

        // Unknown opcode (j): NOP controls but still valid
        drive(32'h0800_0000, 32'h0000_0038, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("nop_ctrl", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);
        check_eq("nop_valid", {31'b0, id_ex_valid}, 32'h1);

        // Asynchronous reset mid-cycle with a live instruction in the latch
        drive(32'h0043_2020, 32'h0000_003C, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("pre_rst_valid", {31'b0, id_ex_valid}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'b0, id_ex_valid}, 32'h0);
        check_eq("async_rst_rd1", id_ex_readdat1, 32'h0);
        check_eq("async_rst_ex", {28'b0, id_ex_ex}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0043_2020, 32'h0000_0040, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("post_rst_valid", {31'b0, id_ex_valid}, 32'h1);
        check_eq("post_rst_r2", id_ex_readdat1, 32'h0);
        check_eq("post_rst_r3", id_ex_readdat2, 32'h0);
        check_eq("post_rst_npc", id_ex_npc, 32'h0000_0040);
        drive(32'h1022_FFFC, 32'h0000_0044, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_eq("post_rst_r1", id_ex_readdat1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
